// File: rtl/player_hit_detector_pkg.sv
// Shared game definitions: FSM states, screen geometry, coordinate width and
// default sprite sizes used by the position stage, hit detector and renderer.
package player_hit_detector_pkg;

  localparam int COORD_W      = 10;
  localparam int EXT_W        = COORD_W + 1;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int SPRITE_W     = 32;
  localparam int SPRITE_H     = 32;
  localparam int PLAYER_Y_DEF = 400;
  localparam int LIVES_W      = 3;
  localparam int INVULN_W     = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SCAN      = 2'd1,
    RESOLVE   = 2'd2,
    GAME_OVER = 2'd3
  } game_state_e;

  // Far edge of a box, widened by one bit so edges near 1023 never wrap.
  function automatic logic [EXT_W-1:0] far_edge(input logic [COORD_W-1:0] c,
                                                input int unsigned sz);
    return {1'b0, c} + EXT_W'(sz);
  endfunction

endpackage

// File: rtl/player_hit_detector_box_overlap.sv
// Purely combinational axis-aligned bounding-box test between box A and box B.
// Strict inequalities: boxes that only share an edge do not overlap.
module box_overlap
  import player_hit_detector_pkg::*;
#(
  parameter int unsigned A_W = SPRITE_W,
  parameter int unsigned A_H = SPRITE_H,
  parameter int unsigned B_W = SPRITE_W,
  parameter int unsigned B_H = SPRITE_H
) (
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  output logic               overlap
);

  logic x_lo_s;
  logic x_hi_s;
  logic y_lo_s;
  logic y_hi_s;

  // Four edge comparisons, all done in the widened coordinate space.
  always_comb begin
    x_lo_s  = ({1'b0, ax} < far_edge(bx, B_W));
    x_hi_s  = ({1'b0, bx} < far_edge(ax, A_W));
    y_lo_s  = ({1'b0, ay} < far_edge(by, B_H));
    y_hi_s  = ({1'b0, by} < far_edge(ay, A_H));
    overlap = x_lo_s && x_hi_s && y_lo_s && y_hi_s;
  end

endmodule

// File: rtl/player_hit_detector.sv
// Per-frame player/obstacle collision detector with lives, post-hit
// invulnerability and game-over handling.
module player_hit_detector
  import player_hit_detector_pkg::*;
#(
  parameter int PLAYER_Y      = PLAYER_Y_DEF,
  parameter int PLAYER_W      = SPRITE_W,
  parameter int PLAYER_H      = SPRITE_H,
  parameter int OBS_W         = SPRITE_W,
  parameter int OBS_H         = SPRITE_H,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               restart,
  input  logic [COORD_W-1:0] player_x,
  input  logic               obs_valid,
  output logic               obs_ready,
  input  logic [COORD_W-1:0] obs_x,
  input  logic [COORD_W-1:0] obs_y,
  input  logic               obs_last,
  output logic               hit,
  output logic [LIVES_W-1:0] lives,
  output logic               invuln,
  output logic               game_over,
  output logic               overrun
);

  localparam logic [COORD_W-1:0]  PLAYER_Y_C = COORD_W'(PLAYER_Y);
  localparam logic [LIVES_W-1:0]  LIVES_C    = LIVES_W'(LIVES);
  localparam logic [INVULN_W-1:0] INVULN_C   = INVULN_W'(INVULN_FRAMES);

  game_state_e          state_r;
  logic [COORD_W-1:0]   px_r;
  logic                 collide_r;
  logic [INVULN_W-1:0]  inv_cnt_r;
  logic [LIVES_W-1:0]   lives_r;
  logic                 hit_r;
  logic                 invuln_r;
  logic                 game_over_r;
  logic                 overrun_r;
  logic                 beat_s;
  logic                 overlap_s;

  box_overlap #(
    .A_W (PLAYER_W),
    .A_H (PLAYER_H),
    .B_W (OBS_W),
    .B_H (OBS_H)
  ) u_overlap (
    .ax      (px_r),
    .ay      (PLAYER_Y_C),
    .bx      (obs_x),
    .by      (obs_y),
    .overlap (overlap_s)
  );

  // Ready is a pure decode of the state register so it follows reset at once.
  assign obs_ready = (state_r == SCAN);
  assign beat_s    = obs_valid && obs_ready;

  assign hit       = hit_r;
  assign lives     = lives_r;
  assign invuln    = invuln_r;
  assign game_over = game_over_r;
  assign overrun   = overrun_r;

  // Game FSM: frame scan, hit resolution, lives/invulnerability bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      px_r        <= {COORD_W{1'b0}};
      collide_r   <= 1'b0;
      inv_cnt_r   <= {INVULN_W{1'b0}};
      lives_r     <= LIVES_C;
      hit_r       <= 1'b0;
      invuln_r    <= 1'b0;
      game_over_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (restart) begin
      state_r     <= IDLE;
      collide_r   <= 1'b0;
      inv_cnt_r   <= {INVULN_W{1'b0}};
      lives_r     <= LIVES_C;
      hit_r       <= 1'b0;
      invuln_r    <= 1'b0;
      game_over_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      hit_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (frame_tick) begin
            px_r      <= player_x;
            collide_r <= 1'b0;
            state_r   <= SCAN;
            if (inv_cnt_r != {INVULN_W{1'b0}}) begin
              inv_cnt_r <= inv_cnt_r - 8'd1;
              invuln_r  <= (inv_cnt_r != 8'd1);
            end
          end
        end
        SCAN: begin
          if (frame_tick) begin
            overrun_r <= 1'b1;
          end
          if (beat_s) begin
            collide_r <= collide_r | overlap_s;
            if (obs_last) begin
              state_r <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          if (frame_tick) begin
            overrun_r <= 1'b1;
          end
          // A collision only costs a life when not already invulnerable.
          if (collide_r && (inv_cnt_r == {INVULN_W{1'b0}}) &&
              (lives_r != {LIVES_W{1'b0}})) begin
            hit_r     <= 1'b1;
            lives_r   <= lives_r - 3'd1;
            inv_cnt_r <= INVULN_C;
            invuln_r  <= (INVULN_C != {INVULN_W{1'b0}});
            if (lives_r == 3'd1) begin
              state_r     <= GAME_OVER;
              game_over_r <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        GAME_OVER: begin
          lives_r     <= {LIVES_W{1'b0}};
          game_over_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_hit_detector.sv
// Randomized scoreboard bench for player_hit_detector against a frame-level model.
module tb_player_hit_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       restart;
  logic [9:0] player_x;
  logic       obs_valid;
  logic       obs_ready;
  logic [9:0] obs_x;
  logic [9:0] obs_y;
  logic       obs_last;
  logic       hit;
  logic [2:0] lives;
  logic       invuln;
  logic       game_over;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int e_hit;
    int e_lives;
    int e_inv;
    int e_go;
  } exp_t;

  exp_t sb_q[$];

  // Frame-level reference state
  int m_lives = 3;
  int m_inv   = 0;
  int m_go    = 0;

  int fo_x[8];
  int fo_y[8];

  always #5 clk = ~clk;

  player_hit_detector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .restart    (restart),
    .player_x   (player_x),
    .obs_valid  (obs_valid),
    .obs_ready  (obs_ready),
    .obs_x      (obs_x),
    .obs_y      (obs_y),
    .obs_last   (obs_last),
    .hit        (hit),
    .lives      (lives),
    .invuln     (invuln),
    .game_over  (game_over),
    .overrun    (overrun)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit boxes_touch(input int px, input int ox, input int oy);
    return (px < ox + 32) && (ox < px + 32) && (400 < oy + 32) && (oy < 400 + 32);
  endfunction

  // Monitor: the end of a scan is seen as obs_ready falling; the verdict is
  // visible one cycle later.
  initial begin
    bit   prev_ready = 1'b0;
    bit   slot = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ready = 1'b0;
        slot = 1'b0;
      end else begin
        if (slot) begin
          slot = 1'b0;
          if (sb_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("hit_pulse", int'(hit), e.e_hit);
            chk("lives", int'(lives), e.e_lives);
            chk("invuln", int'(invuln), e.e_inv);
            chk("game_over", int'(game_over), e.e_go);
          end
        end else begin
          chk("no_spurious_hit", int'(hit), 0);
        end
        if (prev_ready && !obs_ready) slot = 1'b1;
        prev_ready = obs_ready;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic run_frame(input int px, input int n);
    bit   col = 1'b0;
    exp_t e;
    @(negedge clk);
    frame_tick = 1'b1;
    player_x   = 10'(px);
    @(negedge clk);
    frame_tick = 1'b0;
    if (m_go != 0) begin
      chk("go_no_scan", int'(obs_ready), 0);
      repeat (3) @(negedge clk);
      chk("go_still_idle", int'(obs_ready), 0);
      chk("go_lives_zero", int'(lives), 0);
      return;
    end
    chk("scan_start", int'(obs_ready), 1);
    if (m_inv > 0) m_inv--;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        obs_valid = 1'b0;
        @(negedge clk);
      end
      obs_valid = 1'b1;
      obs_x     = 10'(fo_x[i]);
      obs_y     = 10'(fo_y[i]);
      obs_last  = (i == n - 1);
      if (boxes_touch(px, fo_x[i], fo_y[i])) col = 1'b1;
      @(negedge clk);
    end
    obs_valid = 1'b0;
    obs_last  = 1'b0;
    e.e_hit = 0;
    if (col && m_inv == 0 && m_lives > 0) begin
      e.e_hit = 1;
      m_lives--;
      m_inv = 60;
      if (m_lives == 0) m_go = 1;
    end
    e.e_lives = m_lives;
    e.e_inv   = (m_inv != 0) ? 1 : 0;
    e.e_go    = m_go;
    sb_q.push_back(e);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    m_lives = 3;
    m_inv   = 0;
    m_go    = 0;
    chk("restart_lives", int'(lives), 3);
    chk("restart_go", int'(game_over), 0);
    chk("restart_invuln", int'(invuln), 0);
    chk("restart_ready", int'(obs_ready), 0);
  endtask

  task automatic offscreen_frame(input int px);
    fo_x[0] = 0;
    fo_y[0] = 500;
    run_frame(px, 1);
  endtask

  initial begin
    exp_t e;
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    restart    = 1'b0;
    player_x   = 10'd0;
    obs_valid  = 1'b0;
    obs_x      = 10'd0;
    obs_y      = 10'd0;
    obs_last   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_lives", int'(lives), 3);
    chk("rst_go", int'(game_over), 0);
    chk("rst_invuln", int'(invuln), 0);
    chk("rst_ready", int'(obs_ready), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    offscreen_frame(100);

    // First hit, then the 60-frame invulnerability window with a collision at frame 10
    fo_x[0] = 110; fo_y[0] = 390;
    run_frame(100, 1);
    for (int f = 1; f <= 60; f++) begin
      if (f == 10) begin
        fo_x[0] = 110; fo_y[0] = 390;
        run_frame(100, 1);
      end else begin
        offscreen_frame(100);
      end
      if (f == 59) chk("invuln_frame59", int'(invuln), 1);
      if (f == 60) chk("invuln_frame60", int'(invuln), 0);
    end

    // Touching edge vs one-pixel overlap
    fo_x[0] = 132; fo_y[0] = 400;
    run_frame(100, 1);
    chk("edge_touch_lives", int'(lives), 2);
    fo_x[0] = 131; fo_y[0] = 400;
    run_frame(100, 1);
    chk("edge_overlap_lives", int'(lives), 1);
    for (int f = 0; f < 60; f++) offscreen_frame(100);

    // Five-beat stream, only the 4th collides
    fo_x[0] = 300; fo_y[0] = 400;
    fo_x[1] = 10;  fo_y[1] = 100;
    fo_x[2] = 140; fo_y[2] = 400;
    fo_x[3] = 115; fo_y[3] = 420;
    fo_x[4] = 60;  fo_y[4] = 400;
    run_frame(100, 5);
    chk("final_hit_go", int'(game_over), 1);
    offscreen_frame(100);
    do_restart();

    // Randomized play
    for (int f = 0; f < 250; f++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        fo_x[i] = $urandom_range(0, 639);
        fo_y[i] = ($urandom_range(0, 7) == 0) ? 480 + $urandom_range(0, 40)
                                              : $urandom_range(330, 479);
      end
      run_frame($urandom_range(0, 607), n);
      if (m_go != 0) begin
        offscreen_frame(50);
        do_restart();
      end
    end
    if (m_go != 0) do_restart();

    // Overrun: second frame_tick while the stream is stalled
    @(negedge clk);
    frame_tick = 1'b1;
    player_x   = 10'd200;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("ovr_scan_start", int'(obs_ready), 1);
    if (m_inv > 0) m_inv--;
    repeat (2) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("overrun_set", int'(overrun), 1);
    repeat (3) @(negedge clk);
    chk("overrun_sticky", int'(overrun), 1);
    obs_valid = 1'b1;
    obs_x     = 10'd0;
    obs_y     = 10'd500;
    obs_last  = 1'b1;
    @(negedge clk);
    obs_valid = 1'b0;
    obs_last  = 1'b0;
    e.e_hit   = 0;
    e.e_lives = m_lives;
    e.e_inv   = (m_inv != 0) ? 1 : 0;
    e.e_go    = 0;
    sb_q.push_back(e);
    repeat (3) @(negedge clk);
    chk("overrun_after_frame", int'(overrun), 1);

    // restart wins over a simultaneous frame_tick
    @(negedge clk);
    restart    = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    restart    = 1'b0;
    frame_tick = 1'b0;
    m_lives = 3;
    m_inv   = 0;
    m_go    = 0;
    chk("prio_no_scan", int'(obs_ready), 0);
    chk("prio_overrun_clr", int'(overrun), 0);
    chk("prio_lives", int'(lives), 3);
    repeat (2) @(negedge clk);
    chk("prio_still_idle", int'(obs_ready), 0);

    offscreen_frame(100);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
